// File: rtl/seven_seg_rx_if.sv
// seven_seg_rx_if: bundles the multiplexed seven-segment bus sample and the
//    decoded byte / status pulses of the seven_seg_rx monitor.
// Ports (modports):
//    master - drives seg_in, observes dout, dout_valid, seg_err (bench / board side)
//    slave  - samples seg_in, drives dout, dout_valid, seg_err (the decoder)
interface seven_seg_rx_if;
   logic [7:0] seg_in;      // bit 7 digit select (1 = LSB digit), bits 6:0 active-low g..a
   logic [7:0] dout;        // last decoded byte {msb_nibble, lsb_nibble}
   logic       dout_valid;  // one-cycle pulse when dout updates
   logic       seg_err;     // one-cycle pulse on an accepted illegal glyph

   modport master (
      output seg_in,
      input  dout,
      input  dout_valid,
      input  seg_err
   );

   modport slave (
      input  seg_in,
      output dout,
      output dout_valid,
      output seg_err
   );
endinterface

// File: rtl/seven_seg_rx.sv
// seven_seg_rx: decodes a muxed two-digit seven-segment bus back into bytes.
// Latency: STABLE_CYCLES+2 clk cycles from a seg_in pin change to dout_valid/seg_err.
// Backpressure: none; the bus is observed passively, pulses are one cycle wide.
//
// Ports:
//    clk   - rising-edge clock for all state
//    rst_n - asynchronous active-low reset
//    bus   - seven_seg_rx_if.slave: seg_in in, dout/dout_valid/seg_err out
// Parameter:
//    STABLE_CYCLES - identical synchronized samples needed to accept a pattern (2..1023)
// Build option:
//    SEVEN_SEG_RX_CHANGE_ONLY_EN - when defined, a completed pair only pulses
//    dout_valid if the byte differs from the last emitted byte (or is the first
//    byte since reset); otherwise every completed pair is emitted.
module seven_seg_rx #(
   parameter int STABLE_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   seven_seg_rx_if.slave bus
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   // The counter holds the number of cycles the current value has matched its
   // predecessor, so a run of N identical cycles shows cnt == N-2 on its N-th
   // cycle (the first cycle of a run is the one where it differs from prev).
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(STABLE_CYCLES - 2);

   // Idle bus: blank segments with LSB select.
   localparam logic [7:0] BUS_IDLE = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      HAVE_LSB,
      HAVE_MSB
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronizer and stability filter
   // ------------------------------------------------------------------
   logic [7:0]       sync1;
   logic [7:0]       sync2;
   logic [7:0]       prev;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= BUS_IDLE;
         sync2 <= BUS_IDLE;
         prev  <= BUS_IDLE;
      end else begin
         sync1 <= bus.seg_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   logic same_as_prev;
   assign same_as_prev = (sync2 == prev);

   // Saturates instead of wrapping so a value held forever is accepted once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!same_as_prev) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   logic accept;
   assign accept = same_as_prev && (cnt == ACCEPT_AT);

   // ------------------------------------------------------------------
   // Glyph decode of the synchronized sample
   // ------------------------------------------------------------------
   logic [6:0] seg_hi;     // active-high segments g..a
   logic       is_lsb;
   logic       is_blank;
   logic       glyph_ok;
   logic [3:0] glyph_nib;

   assign seg_hi   = ~sync2[6:0];
   assign is_lsb   = sync2[7];
   assign is_blank = (seg_hi == 7'h00);

   always_comb begin
      glyph_ok  = 1'b1;
      glyph_nib = 4'h0;
      case (seg_hi)
         7'h3F: glyph_nib = 4'h0;
         7'h06: glyph_nib = 4'h1;
         7'h5B: glyph_nib = 4'h2;
         7'h4F: glyph_nib = 4'h3;
         7'h66: glyph_nib = 4'h4;
         7'h6D: glyph_nib = 4'h5;
         7'h7D: glyph_nib = 4'h6;
         7'h07: glyph_nib = 4'h7;
         7'h7F: glyph_nib = 4'h8;
         7'h6F: glyph_nib = 4'h9;
         7'h77: glyph_nib = 4'hA;
         7'h7C: glyph_nib = 4'hB;
         7'h39: glyph_nib = 4'hC;
         7'h5E: glyph_nib = 4'hD;
         7'h79: glyph_nib = 4'hE;
         7'h71: glyph_nib = 4'hF;
         default: glyph_ok = 1'b0;
      endcase
   end

   // Blank patterns are digit-off periods of the display mux, not data.
   logic digit_evt;
   logic bad_evt;
   assign digit_evt = accept && !is_blank && glyph_ok;
   assign bad_evt   = accept && !is_blank && !glyph_ok;

   // ------------------------------------------------------------------
   // Pairing FSM
   // ------------------------------------------------------------------
   state_t     state_q, state_d;
   logic [3:0] lsb_q, lsb_d;
   logic [3:0] msb_q, msb_d;
   logic       pair_done;
   logic [7:0] pair_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lsb_q   <= 4'h0;
         msb_q   <= 4'h0;
      end else begin
         state_q <= state_d;
         lsb_q   <= lsb_d;
         msb_q   <= msb_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lsb_d     = lsb_q;
      msb_d     = msb_q;
      pair_done = 1'b0;
      pair_byte = 8'h00;

      if (bad_evt) begin
         // A bad glyph poisons any half-built pair.
         state_d = IDLE;
         lsb_d   = 4'h0;
         msb_d   = 4'h0;
      end else if (digit_evt) begin
         case (state_q)
            IDLE: begin
               if (is_lsb) begin
                  lsb_d   = glyph_nib;
                  state_d = HAVE_LSB;
               end else begin
                  msb_d   = glyph_nib;
                  state_d = HAVE_MSB;
               end
            end
            HAVE_LSB: begin
               if (is_lsb) begin
                  lsb_d = glyph_nib;
               end else begin
                  pair_done = 1'b1;
                  pair_byte = {glyph_nib, lsb_q};
                  lsb_d     = 4'h0;
                  msb_d     = 4'h0;
                  state_d   = IDLE;
               end
            end
            HAVE_MSB: begin
               if (!is_lsb) begin
                  msb_d = glyph_nib;
               end else begin
                  pair_done = 1'b1;
                  pair_byte = {msb_q, glyph_nib};
                  lsb_d     = 4'h0;
                  msb_d     = 4'h0;
                  state_d   = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               lsb_d   = 4'h0;
               msb_d   = 4'h0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------
   logic [7:0] dout_q;
   logic       valid_q;
   logic       err_q;
   logic       emit;

`ifdef SEVEN_SEG_RX_CHANGE_ONLY_EN
   // dout_q always equals the last emitted byte, so it doubles as the
   // comparison reference; first_q covers the case where that byte is 00.
   logic first_q;

   assign emit = pair_done && (first_q || (pair_byte != dout_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= 1'b1;
      end else if (emit) begin
         first_q <= 1'b0;
      end
   end
`else
   assign emit = pair_done;
`endif

   // bad_evt and pair_done are mutually exclusive, so the pulses never overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q  <= 8'h00;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= emit;
         err_q   <= bad_evt;
         if (emit) begin
            dout_q <= pair_byte;
         end
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = valid_q;
   assign bus.seg_err    = err_q;

endmodule
